// File: rtl/fp_divider.sv
// fp_divider: iterative binary32 divider, Out = A / B.
// Restoring division, one quotient bit per cycle, then round to nearest-even.
module fp_divider #(
    parameter int QBITS = 26
) (
    input  logic        int_clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Out,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    localparam int CW = $clog2(QBITS);
    localparam logic [CW-1:0] LAST = CW'(QBITS - 1);

    typedef enum logic [1:0] {IDLE, PREP, DIVIDE, ROUND} state_t;

    state_t            state;
    logic [31:0]       a_q, b_q;
    logic [24:0]       rem;
    logic [23:0]       mb;
    logic [QBITS-1:0]  quo;
    logic [CW-1:0]     cnt;
    logic signed [9:0] exp_q;
    logic              sign_q;

    // operand classification; exponent 0 means zero (denormals flushed)
    logic [7:0]  ea, eb;
    logic        sgn;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [23:0] ma_n, mb_n;
    logic        ma_lt;
    logic [24:0] ma_adj;
    logic signed [9:0] exp_n;

    assign ea     = a_q[30:23];
    assign eb     = b_q[30:23];
    assign sgn    = a_q[31] ^ b_q[31];
    assign a_zero = (ea == 8'd0);
    assign b_zero = (eb == 8'd0);
    assign a_inf  = (ea == 8'hff) && (a_q[22:0] == 23'd0);
    assign b_inf  = (eb == 8'hff) && (b_q[22:0] == 23'd0);
    assign a_nan  = (ea == 8'hff) && (a_q[22:0] != 23'd0);
    assign b_nan  = (eb == 8'hff) && (b_q[22:0] != 23'd0);
    assign ma_n   = {1'b1, a_q[22:0]};
    assign mb_n   = {1'b1, b_q[22:0]};
    assign ma_lt  = (ma_n < mb_n);
    assign ma_adj = ma_lt ? {ma_n, 1'b0} : {1'b0, ma_n};
    assign exp_n  = $signed({2'b00, ea}) - $signed({2'b00, eb})
                  + 10'sd127 - (ma_lt ? 10'sd1 : 10'sd0);

    // special-case result selection in priority order
    logic        spec_hit;
    logic        spec_dz;
    logic [31:0] spec_out;

    always_comb begin
        spec_hit = 1'b1;
        spec_dz  = 1'b0;
        spec_out = 32'h7fc00000;
        if (a_nan || b_nan) begin
            spec_out = 32'h7fc00000;
        end else if (a_zero && b_zero) begin
            spec_out = 32'h7fc00000;
        end else if (a_inf && b_inf) begin
            spec_out = 32'h7fc00000;
        end else if (a_inf) begin
            spec_out = {sgn, 8'hff, 23'd0};
        end else if (b_inf) begin
            spec_out = {sgn, 31'd0};
        end else if (b_zero) begin
            spec_out = {sgn, 8'hff, 23'd0};
            spec_dz  = 1'b1;
        end else if (a_zero) begin
            spec_out = {sgn, 31'd0};
        end else begin
            spec_hit = 1'b0;
        end
    end

    // one restoring-division step
    logic        rem_ge;
    logic [24:0] rem_sub;
    logic [24:0] rem_next;

    assign rem_ge   = (rem >= {1'b0, mb});
    assign rem_sub  = rem_ge ? (rem - {1'b0, mb}) : rem;
    assign rem_next = rem_sub << 1;

    // round to nearest-even using guard, round and sticky remainder
    logic        rnd_up;
    logic [24:0] mant;
    logic signed [9:0] exp_r;
    logic [22:0] frac_r;
    logic [31:0] round_out;

    always_comb begin
        rnd_up = quo[1] & (quo[0] | (rem != 25'd0) | quo[2]);
        mant   = {1'b0, quo[QBITS-1 -: 24]} + {24'd0, rnd_up};
        exp_r  = exp_q + (mant[24] ? 10'sd1 : 10'sd0);
        frac_r = mant[24] ? mant[23:1] : mant[22:0];
        if (exp_r >= 10'sd255) begin
            round_out = {sign_q, 8'hff, 23'd0};
        end else if (exp_r <= 10'sd0) begin
            round_out = {sign_q, 31'd0};
        end else begin
            round_out = {sign_q, exp_r[7:0], frac_r};
        end
    end

    // control FSM with registered outputs
    always_ff @(posedge int_clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            Out         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            rem         <= '0;
            mb          <= '0;
            quo         <= '0;
            cnt         <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B;
                        busy  <= 1'b1;
                        state <= PREP;
                    end
                end
                PREP: begin
                    if (spec_hit) begin
                        Out         <= spec_out;
                        div_by_zero <= spec_dz;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        rem    <= ma_adj;
                        mb     <= mb_n;
                        exp_q  <= exp_n;
                        sign_q <= sgn;
                        quo    <= '0;
                        cnt    <= '0;
                        state  <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    quo <= {quo[QBITS-2:0], rem_ge};
                    rem <= rem_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    Out         <= round_out;
                    div_by_zero <= 1'b0;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_divider.sv
// tb_fp_divider: directed and random checks of fp_divider
// against an exact-arithmetic reference model.
module tb_fp_divider;

    logic        int_clk;
    logic        reset;
    logic        start;
    logic [31:0] A, B;
    logic [31:0] Out;
    logic        busy, done, div_by_zero;

    int errors = 0;
    int checks = 0;

    fp_divider dut (
        .int_clk     (int_clk),
        .reset       (reset),
        .start       (start),
        .A           (A),
        .B           (B),
        .Out         (Out),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial int_clk = 1'b0;
    always #5 int_clk = ~int_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer quotient with 40 extra bits, then RNE.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic dz,
                                    output bit sp);
        bit s;
        int ea, eb, e, top;
        bit an, bn, ai, bi, az, bz, up;
        longint unsigned ma, mb, num, q, rm, keep, rest, half;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        an = (ea == 255) && (a[22:0] != 0);
        bn = (eb == 255) && (b[22:0] != 0);
        ai = (ea == 255) && (a[22:0] == 0);
        bi = (eb == 255) && (b[22:0] == 0);
        az = (ea == 0);
        bz = (eb == 0);
        dz = 1'b0;
        sp = 1'b1;
        if (an || bn)      r = 32'h7fc00000;
        else if (az && bz) r = 32'h7fc00000;
        else if (ai && bi) r = 32'h7fc00000;
        else if (ai)       r = {s, 8'hff, 23'd0};
        else if (bi)       r = {s, 31'd0};
        else if (bz) begin
            r  = {s, 8'hff, 23'd0};
            dz = 1'b1;
        end
        else if (az)       r = {s, 31'd0};
        else begin
            sp  = 1'b0;
            ma  = 64'h800000 | 64'(a[22:0]);
            mb  = 64'h800000 | 64'(b[22:0]);
            num = ma << 40;
            q   = num / mb;
            rm  = num % mb;
            e   = ea - eb + 127;
            top = 40;
            if (ma < mb) begin
                e   = e - 1;
                top = 39;
            end
            keep = q >> (top - 23);
            rest = q & ((64'd1 << (top - 23)) - 1);
            half = 64'd1 << (top - 24);
            up   = (rest > half) || ((rest == half) && ((rm != 0) || keep[0]));
            keep = keep + (up ? 64'd1 : 64'd0);
            if (keep == (64'd1 << 24)) begin
                keep = keep >> 1;
                e    = e + 1;
            end
            if (e >= 255)    r = {s, 8'hff, 23'd0};
            else if (e <= 0) r = {s, 31'd0};
            else             r = {s, e[7:0], keep[22:0]};
        end
    endfunction

    // Count edges after acceptance until done; busy must stay high.
    task automatic wait_done(output int n, output bit busy_ok);
        n       = 0;
        busy_ok = 1'b1;
        while (!done && n < 60) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge int_clk);
            #1;
            n++;
        end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        logic [31:0] eo;
        logic        edz;
        bit          sp, bok;
        int          n;
        ref_div(a, b, eo, edz, sp);
        @(negedge int_clk);
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge int_clk);
        #1;
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        wait_done(n, bok);
        chk({tag, " out"}, Out, eo);
        chk({tag, " dz"}, 32'(div_by_zero), 32'(edz));
        chk({tag, " lat"}, n, sp ? 1 : 28);
        chk({tag, " busy"}, 32'(bok), 32'd1);
        chk({tag, " busy_end"}, 32'(busy), 32'd0);
        @(posedge int_clk);
        #1;
        chk({tag, " pulse"}, 32'(done), 32'd0);
    endtask

    function automatic logic [31:0] rnd_num();
        logic [7:0] e;
        e = 8'(64 + $urandom_range(0, 126));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    initial begin
        int  n;
        bit  bok;
        logic [31:0] ra, rb;
        reset = 1'b0;
        start = 1'b0;
        A     = '0;
        B     = '0;
        #2 reset = 1'b1;
        start = 1'b1;
        A     = 32'h41200000;
        B     = 32'h40000000;
        repeat (2) @(posedge int_clk);
        #1;
        chk("rst out", Out, 32'h0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst dz", 32'(div_by_zero), 32'd0);
        @(negedge int_clk);
        start = 1'b0;
        reset = 1'b0;

        do_op(32'h41200000, 32'h40000000, "10/2");
        chk("10/2 exact", Out, 32'h40a00000);
        do_op(32'hc1720000, 32'h40300000, "neg");
        chk("neg exact", Out, 32'hc0b00000);
        do_op(32'h3f800000, 32'h40400000, "1/3");
        chk("1/3 exact", Out, 32'h3eaaaaab);
        do_op(32'h40a00000, 32'h00000000, "x/0");
        chk("x/0 dz", 32'(div_by_zero), 32'd1);
        do_op(32'h00000000, 32'h00000000, "0/0");
        chk("0/0 exact", Out, 32'h7fc00000);
        do_op(32'h7f800000, 32'hc0000000, "inf/x");
        chk("inf/x exact", Out, 32'hff800000);
        do_op(32'h7f7fffff, 32'h3f000000, "ovf");
        chk("ovf exact", Out, 32'h7f800000);
        do_op(32'h00800000, 32'h40000000, "unf");
        chk("unf exact", Out, 32'h00000000);
        do_op(32'h7fc00001, 32'h3f800000, "nan");
        do_op(32'h7f800000, 32'h7f800000, "inf/inf");
        do_op(32'h3f800000, 32'hff800000, "x/inf");
        do_op(32'h80000000, 32'h40000000, "0/x");

        // start during busy is ignored
        @(negedge int_clk);
        A     = 32'h41200000;
        B     = 32'h40000000;
        start = 1'b1;
        @(posedge int_clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge int_clk);
        @(negedge int_clk);
        A     = 32'h3f800000;
        B     = 32'h40400000;
        start = 1'b1;
        @(posedge int_clk);
        #1;
        start = 1'b0;
        wait_done(n, bok);
        chk("ign lat", n + 6, 28);
        chk("ign out", Out, 32'h40a00000);
        repeat (3) @(posedge int_clk);
        #1;
        chk("ign noqueue", 32'(busy), 32'd0);

        // start held through done: accepted on the following edge
        @(negedge int_clk);
        A     = 32'h3f800000;
        B     = 32'h40400000;
        start = 1'b1;
        @(posedge int_clk);
        #1;
        wait_done(n, bok);
        chk("hold lat", n, 28);
        chk("hold busy_at_done", 32'(busy), 32'd0);
        @(posedge int_clk);
        #1;
        start = 1'b0;
        chk("hold accept", 32'(busy), 32'd1);
        chk("hold pulse", 32'(done), 32'd0);
        wait_done(n, bok);
        chk("hold lat2", n, 28);
        chk("hold out", Out, 32'h3eaaaaab);

        // async reset mid-divide
        @(negedge int_clk);
        A     = 32'h41200000;
        B     = 32'h40000000;
        start = 1'b1;
        @(posedge int_clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge int_clk);
        #2 reset = 1'b1;
        start = 1'b1;
        #1;
        chk("mid rst out", Out, 32'h0);
        chk("mid rst busy", 32'(busy), 32'd0);
        chk("mid rst done", 32'(done), 32'd0);
        @(posedge int_clk);
        #1;
        chk("rst start ign", 32'(busy), 32'd0);
        @(negedge int_clk);
        start = 1'b0;
        reset = 1'b0;
        @(posedge int_clk);
        #1;
        chk("post rst idle", 32'(busy), 32'd0);
        do_op(32'h40b00000, 32'h40300000, "after rst");
        chk("after rst exact", Out, 32'h40000000);

        // random normal-range operands
        for (int i = 0; i < 30; i++) begin
            ra = rnd_num();
            rb = rnd_num();
            do_op(ra, rb, $sformatf("rnd%0d", i));
        end
        // fully random bit patterns
        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = $urandom;
            do_op(ra, rb, $sformatf("raw%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_divider.md
Name: fp_divider

Overview:
- Iterative single-precision IEEE-754 divider, Out = A / B.
- Complements fp_multiplier in the FPU arithmetic path.
- Uses a start/busy/done handshake instead of a fixed clock-ratio window.
- Computes the quotient mantissa with one restoring-division step per int_clk cycle, then rounds to nearest-even.

Parameters:
- QBITS, 26, quotient bits generated: 24 significand + guard + round. Fixed for binary32; not intended to be overridden.

Ports:
- int_clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- A  in  32  dividend, binary32; captured on the accepting edge.
- B  in  32  divisor, binary32; captured on the accepting edge.
- Out  out  32  result, binary32; registered, holds until the next result.
- busy  out  1  high from the accepting edge until the edge that asserts done.
- done  out  1  one-cycle pulse when Out is updated.
- div_by_zero  out  1  flag written together with Out; high for finite nonzero / zero.

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE; Out=0, busy=0, done=0, div_by_zero=0.
  - Iteration counter and remainder cleared.
  - A start during reset is ignored.
- States: IDLE, PREP, DIVIDE, ROUND.
- IDLE:
  - On start=1: latch A/B, busy<=1, go to PREP.
  - done<=0 on every edge in which no result is written.
- PREP (one edge):
  - Classify operands. Exponent 0 counts as zero; denormals are flushed to zero.
  - If a special case applies: write Out and div_by_zero, done<=1, busy<=0, go to IDLE. Latency is 1 edge after the accepting edge.
  - Otherwise:
    - ma={1,A[22:0]}, mb={1,B[22:0]}.
    - If ma<mb: ma<<=1 and exp adjust = -1.
    - exp = ea - eb + 127 + adjust, held as 10-bit signed.
    - Load remainder=ma, counter=0, go to DIVIDE.
- DIVIDE:
  - Each edge: if rem>=mb then q bit=1 and rem-=mb; then rem<<=1.
  - Quotient bits are produced MSB first.
  - After QBITS edges, go to ROUND.
  - The first quotient bit is always 1.
- ROUND (one edge):
  - sticky = (rem!=0).
  - Round to nearest-even on guard/round/sticky.
  - Mantissa carry-out to 2.0: renormalize and exp+1.
  - exp>=255 -> signed Inf. exp<=0 -> signed zero (no subnormal output).
  - Write Out, done<=1, busy<=0, go to IDLE.
- Normal-path latency: done is high after the 28th rising edge following the accepting edge.
- Result sign is always A[31]^B[31], except for NaN.
- Special cases, in priority order:
  - Either operand NaN -> 7fc00000.
  - 0/0 -> 7fc00000.
  - Inf/Inf -> 7fc00000.
  - Inf/finite -> signed Inf.
  - finite/Inf -> signed 0.
  - nonzero/0 -> signed Inf and div_by_zero=1.
  - 0/nonzero -> signed 0.
- start while busy is ignored and not queued.
- A/B changes after the accepting edge do not affect the result.
- start high on the same edge that done asserts is not accepted. It is accepted on the next edge if still high.

Test Plan:
- 41200000 / 40000000 (10/2) -> Out=40a00000, done pulse exactly 28 edges after start, busy high throughout, div_by_zero=0.
- c1720000 / 40300000 (-15.125/2.75) -> c0b00000; then 3f800000 / 40400000 (1/3) -> 3eaaaaab, checking RNE round-up.
- 40a00000 / 00000000 -> 7f800000 with div_by_zero=1, done 1 edge after start. 00000000 / 00000000 -> 7fc00000. 7f800000 / c0000000 -> ff800000.
- 7f7fffff / 3f000000 -> 7f800000 (overflow). 00800000 / 40000000 -> 00000000 (underflow flush).
- Assert start again at iteration 5 with different A/B -> ignored, first result unchanged. Assert reset at iteration 10 -> Out/busy/done all 0 immediately (async); a following 40b00000/40300000 yields 40000000.
